// File: rtl/demux_dispatch_scheduler_if.sv
// Bus bundle between the serial producer, the dispatch scheduler and the
// 1x4 demux it sequences. Also carries FSM/pointer visibility signals.
//
// Handshake: an item moves from producer to scheduler on a rising clock edge
// where req_valid and req_ready are both high. req_valid/req_data must stay
// stable until that edge. req_ready never depends on req_valid.
// req_data is sampled only on the transferring edge.
interface demux_dispatch_scheduler_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_data;
  logic                   req_ready;
  logic [3:0]             dest_mask;
  logic [3:0]             dest_ready;
  logic                   demux_in;
  logic [1:0]             demux_select;
  logic                   demux_enable;
  logic                   busy;
  logic [1:0]             last_channel;
  logic [COUNT_WIDTH-1:0] dispatch_count;
  logic                   dbg_state;   // 0 = IDLE, 1 = DRIVE
  logic [1:0]             dbg_ptr;     // round-robin pointer

  // Scheduler side
  modport slave (
    input  req_valid, req_data, dest_mask, dest_ready,
    output req_ready, demux_in, demux_select, demux_enable, busy,
           last_channel, dispatch_count, dbg_state, dbg_ptr
  );

  // Producer / environment side
  modport master (
    output req_valid, req_data, dest_mask, dest_ready,
    input  req_ready, demux_in, demux_select, demux_enable, busy,
           last_channel, dispatch_count, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/demux_dispatch_scheduler.sv
// Round-robin dispatcher driving a 1-to-4 demux. Accepts one bit per
// handshake, picks the first eligible channel starting at the pointer,
// holds the demux enabled for HOLD_CYCLES cycles, then advances the pointer.
module demux_dispatch_scheduler #(
  parameter int HOLD_CYCLES = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  demux_dispatch_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [1:0]             ptr_q;
  logic [3:0]             hold_q;
  logic                   din_q;
  logic [1:0]             sel_q;
  logic                   en_q;
  logic                   busy_q;
  logic [1:0]             last_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic [3:0]             elig;
  logic [1:0]             pick;
  logic [1:0]             idx;
  logic                   found;
  logic                   ready_c;
  logic                   accept;
  logic                   finish;

  // Eligible channels: enabled by mask and consumer ready right now
  always_comb begin
    elig = bus.dest_mask & bus.dest_ready;
  end

  // Round-robin pick: first eligible channel scanning ptr, ptr+1, ... (mod 4)
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Ready only in IDLE with something eligible, and never while in reset
  always_comb begin
    ready_c = (state_q == IDLE) && (elig != 4'b0000) && !reset;
  end

  // FSM next-state and transfer/finish strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_c) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q == 4'd0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch item/channel on accept, count down the hold window,
  // retire the dispatch (pointer, last channel, counter) when it ends
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      din_q   <= 1'b0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 2'd0;
      count_q <= '0;
    end else if (accept) begin
      din_q  <= bus.req_data;
      sel_q  <= pick;
      hold_q <= HOLD_LOAD;
      en_q   <= 1'b1;
      busy_q <= 1'b1;
    end else if (finish) begin
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= sel_q + 2'd1;
      last_q  <= sel_q;
      count_q <= count_q + COUNT_WIDTH'(1);
    end else if (state_q == DRIVE) begin
      hold_q <= hold_q - 4'd1;
    end
  end

  // Output mapping; select and data hold their values through IDLE
  always_comb begin
    bus.req_ready      = ready_c;
    bus.demux_in       = din_q;
    bus.demux_select   = sel_q;
    bus.demux_enable   = en_q;
    bus.busy           = busy_q;
    bus.last_channel   = last_q;
    bus.dispatch_count = count_q;
    bus.dbg_state      = (state_q == DRIVE);
    bus.dbg_ptr        = ptr_q;
  end

endmodule

// File: tb/tb_demux_dispatch_scheduler.sv
// Bench for demux_dispatch_scheduler: two instances (hold 1 and hold 3) share
// clock, reset and producer/consumer stimulus; each is checked every cycle
// against a behavioural model, plus a vector table and directed sequences.
module tb_demux_dispatch_scheduler;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       valid = 1'b0;
  logic       data  = 1'b0;
  logic [3:0] mask  = 4'hF;
  logic [3:0] rdy   = 4'hF;

  demux_dispatch_scheduler_if #(.COUNT_WIDTH(CW)) if1 ();
  demux_dispatch_scheduler_if #(.COUNT_WIDTH(CW)) if3 ();

  assign if1.req_valid  = valid;
  assign if1.req_data   = data;
  assign if1.dest_mask  = mask;
  assign if1.dest_ready = rdy;
  assign if3.req_valid  = valid;
  assign if3.req_data   = data;
  assign if3.dest_mask  = mask;
  assign if3.dest_ready = rdy;

  demux_dispatch_scheduler #(.HOLD_CYCLES(1), .COUNT_WIDTH(CW)) dut1 (
    .clock(clock), .reset(reset), .bus(if1)
  );
  demux_dispatch_scheduler #(.HOLD_CYCLES(3), .COUNT_WIDTH(CW)) dut3 (
    .clock(clock), .reset(reset), .bus(if3)
  );

  // ---------------- reference model ----------------
  int m_hold[2] = '{1, 3};
  bit m_drive[2];
  int m_left[2];
  int m_ptr[2];
  int m_last[2];
  int m_cnt[2];
  int m_sel[2];
  int m_din[2];
  bit m_acc[2];

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  logic       prev_en1 = 1'b0;
  logic       smp_rdy1;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int first_elig(int ptr, int elig);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (((elig >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  // One rising edge of the dispatcher, from the behavioural rules
  function automatic void model_edge(int d);
    int c;
    m_acc[d] = 1'b0;
    if (reset) begin
      m_drive[d] = 1'b0; m_left[d] = 0; m_ptr[d] = 0; m_last[d] = 0;
      m_cnt[d] = 0; m_sel[d] = 0; m_din[d] = 0;
      return;
    end
    if (m_drive[d]) begin
      m_left[d]--;
      if (m_left[d] == 0) begin
        m_drive[d] = 1'b0;
        m_ptr[d]   = (m_sel[d] + 1) % 4;
        m_last[d]  = m_sel[d];
        m_cnt[d]   = (m_cnt[d] + 1) % (1 << CW);
      end
    end else begin
      c = first_elig(m_ptr[d], int'(mask & rdy));
      if (valid && c >= 0) begin
        m_sel[d]   = c;
        m_din[d]   = int'(data);
        m_drive[d] = 1'b1;
        m_left[d]  = m_hold[d];
        m_acc[d]   = 1'b1;
      end
    end
  endfunction

  task automatic check_dut(input int d, input logic en, input logic bz,
                           input logic [1:0] sel, input logic din,
                           input logic [1:0] last, input logic [CW-1:0] cnt,
                           input logic [1:0] ptr);
    chk($sformatf("h%0d_enable", m_hold[d]), int'(en), int'(m_drive[d]));
    chk($sformatf("h%0d_busy", m_hold[d]), int'(bz), int'(m_drive[d]));
    chk($sformatf("h%0d_select", m_hold[d]), int'(sel), m_sel[d]);
    chk($sformatf("h%0d_demux_in", m_hold[d]), int'(din), m_din[d]);
    chk($sformatf("h%0d_last", m_hold[d]), int'(last), m_last[d]);
    chk($sformatf("h%0d_count", m_hold[d]), int'(cnt), m_cnt[d]);
    chk($sformatf("h%0d_ptr", m_hold[d]), int'(ptr), m_ptr[d]);
  endtask

  // ---------------- driver: one clock cycle with full checking ----------------
  task automatic step();
    logic [2:0] e;
    @(negedge clock);
    smp_rdy1 = if1.req_ready;
    chk("h1_req_ready", int'(if1.req_ready),
        int'(!reset && !m_drive[0] && ((mask & rdy) != 4'b0)));
    chk("h3_req_ready", int'(if3.req_ready),
        int'(!reset && !m_drive[1] && ((mask & rdy) != 4'b0)));
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    if (reset) exp_q.delete();
    if (m_acc[0]) exp_q.push_back(3'(m_sel[0] * 2 + m_din[0]));
    #1;
    check_dut(0, if1.demux_enable, if1.busy, if1.demux_select, if1.demux_in,
              if1.last_channel, if1.dispatch_count, if1.dbg_ptr);
    check_dut(1, if3.demux_enable, if3.busy, if3.demux_select, if3.demux_in,
              if3.last_channel, if3.dispatch_count, if3.dbg_ptr);
    if (if1.demux_enable && !prev_en1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_dispatch", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dispatch", int'({if1.demux_select, if1.demux_in}), int'(e));
      end
    end
    prev_en1 = if1.demux_enable;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b0;
    data  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       valid;
    logic       data;
    logic       exp_rdy;
    logic       exp_en;
    logic [1:0] exp_sel;
    logic       exp_din;
    logic [7:0] exp_cnt;
    logic [1:0] exp_last;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // four items 1,0,1,1 to a fully eligible hold-1 dispatcher
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'd0, 2'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'd1, 2'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd2, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 8'd2, 2'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 8'd3, 2'd2};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 8'd3, 2'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 8'd4, 2'd3};

    // reset state (mask/ready all set so req_ready is held low by reset alone)
    mask = 4'hF; rdy = 4'hF;
    reset = 1'b1; valid = 1'b1;
    step();
    chk("rst_req_ready", int'(smp_rdy1), 0);
    do_reset();
    chk("rst_enable", int'(if1.demux_enable), 0);
    chk("rst_busy", int'(if1.busy), 0);
    chk("rst_select", int'(if1.demux_select), 0);
    chk("rst_demux_in", int'(if1.demux_in), 0);
    chk("rst_last", int'(if1.last_channel), 0);
    chk("rst_count", int'(if1.dispatch_count), 0);

    // table: round-robin order and one idle cycle between hold-1 pulses
    for (int i = 0; i < 8; i++) begin
      valid = tbl[i].valid;
      data  = tbl[i].data;
      step();
      chk($sformatf("tbl%0d_req_ready", i), int'(smp_rdy1), int'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_enable", i), int'(if1.demux_enable), int'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_select", i), int'(if1.demux_select), int'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_demux_in", i), int'(if1.demux_in), int'(tbl[i].exp_din));
      chk($sformatf("tbl%0d_count", i), int'(if1.dispatch_count), int'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_last", i), int'(if1.last_channel), int'(tbl[i].exp_last));
    end

    // single eligible channel receives every item
    do_reset();
    mask = 4'b0100; rdy = 4'hF; valid = 1'b1; data = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("single_count", int'(if1.dispatch_count), 3);
    chk("single_ptr", int'(if1.dbg_ptr), 3);
    chk("single_select", int'(if1.demux_select), 2);
    chk("single_last", int'(if1.last_channel), 2);

    // nothing ready: producer waits, then one channel frees up
    do_reset();
    mask = 4'hF; rdy = 4'h0; valid = 1'b1; data = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_req_ready", int'(smp_rdy1), 0);
    end
    chk("stall_count", int'(if1.dispatch_count), 0);
    rdy = 4'b0010;
    step();
    chk("unstall_req_ready", int'(smp_rdy1), 1);
    chk("unstall_select", int'(if1.demux_select), 1);
    chk("unstall_enable", int'(if1.demux_enable), 1);

    // hold 3: enable for exactly three cycles, ready drop mid-dispatch ignored
    do_reset();
    mask = 4'hF; rdy = 4'hF; valid = 1'b1; data = 1'b1;
    step();
    valid = 1'b0;
    chk("h3_win_k1", int'(if3.demux_enable), 1);
    step();
    chk("h3_win_k2", int'(if3.demux_enable), 1);
    rdy = 4'b1110;
    step();
    chk("h3_win_k3", int'(if3.demux_enable), 1);
    chk("h3_win_select", int'(if3.demux_select), 0);
    step();
    chk("h3_win_k4", int'(if3.demux_enable), 0);
    chk("h3_win_count", int'(if3.dispatch_count), 1);
    chk("h3_win_last", int'(if3.last_channel), 0);

    // reset in the second cycle of a hold-3 dispatch discards the item
    do_reset();
    mask = 4'hF; rdy = 4'hF; valid = 1'b1; data = 1'b1;
    step();
    valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_enable", int'(if3.demux_enable), 0);
    chk("abort_select", int'(if3.demux_select), 0);
    chk("abort_busy", int'(if3.busy), 0);
    chk("abort_count", int'(if3.dispatch_count), 0);
    chk("abort_ptr", int'(if3.dbg_ptr), 0);

    // counter wrap: 257 hold-1 dispatches
    do_reset();
    mask = 4'hF; rdy = 4'hF; valid = 1'b1;
    for (int i = 0; i < 514; i++) begin
      data = 1'($urandom_range(0, 1));
      step();
    end
    chk("wrap_count", int'(if1.dispatch_count), 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rdy = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
